// File: rtl/accel_ctrl_pkg.sv
//==============================================================================
// Module      : accel_ctrl_pkg
// Description : Shared bus IDs, op encodings, sequencer states and command
//               word field offsets for the accelerator control group.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package accel_ctrl_pkg;

    localparam logic [1:0] c_BUS_ID_MEM   = 2'b00;
    localparam logic [1:0] c_BUS_ID_ACCEL = 2'b10;

    localparam logic [1:0] c_OP_RD = 2'b01;
    localparam logic [1:0] c_OP_OP = 2'b11;
    localparam logic [1:0] c_OP_WR = 2'b10;

    // Command word layout: {addr, aux[1:0], dst[1:0], src[1:0], op[1:0]}
    localparam int c_OFS_OP   = 0;
    localparam int c_OFS_SRC  = 2;
    localparam int c_OFS_DST  = 4;
    localparam int c_OFS_AUX  = 6;
    localparam int c_OFS_ADDR = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/accel_watchdog.sv
//==============================================================================
// Module      : accel_watchdog
// Description : Load-clear / enable saturating counter flagging LIMIT-1 counts
//               (LIMIT = 0 disables the flag).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module accel_watchdog #(
    parameter int WIDTH = 12,
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam bit              c_ENABLED = (LIMIT != 0);
    localparam logic [WIDTH-1:0] c_LAST   = WIDTH'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = c_ENABLED && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/accel_seq_fsm.sv
//==============================================================================
// Module      : accel_seq_fsm
// Description : Accelerator request sequencer: NUM_RD operand reads, one
//               accelerator op, one write-back, then a completion word.
//               Optional perf counters enabled by ACCEL_SEQ_PERF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module accel_seq_fsm
    import accel_ctrl_pkg::*;
#(
    parameter int         ADDRW    = 24,
    parameter logic [1:0] ACCEL_ID = c_BUS_ID_ACCEL,
    parameter logic [1:0] MEM_ID   = c_BUS_ID_MEM,
    parameter int         NUM_RD   = 2,
    parameter int         TO_W     = 12,
    parameter int         TIMEOUT  = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    input  logic [(NUM_RD+1)*ADDRW+1:0]   req_data,
    output logic                          ready_req_out,
    output logic                          arb_req,
    input  logic                          arb_grant,
    input  logic [2:0]                    ack_in,
    output logic [ADDRW+7:0]              data_out,
    input  logic                          compq_ready_in,
    output logic                          compq_valid_out,
    output logic [ADDRW:0]                compq_data_out
`ifdef ACCEL_SEQ_PERF_EN
    ,
    output logic [15:0]                   perf_done,
    output logic [15:0]                   perf_err
`endif
);

    localparam int         c_REQ_W   = (NUM_RD + 1) * ADDRW + 2;
    localparam int         c_CMD_W   = ADDRW + 8;
    localparam logic [2:0] c_STEP_OP = 3'(NUM_RD);
    localparam logic [2:0] c_STEP_WR = 3'(NUM_RD + 1);

    if ((TIMEOUT >= (1 << TO_W)) || (NUM_RD < 1) || (NUM_RD > 4)) begin : g_param_check
        $error("accel_seq_fsm: TIMEOUT must fit TO_W and NUM_RD must be 1..4");
    end

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [2:0]         r_step;
    logic [2:0]         w_step_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [c_REQ_W-1:0] r_buf;
    logic               w_load;
    logic               w_wd_clear;
    logic               w_wd_en;
    logic               w_expired;
    logic [2:0]         w_ack_exp;
    logic [1:0]         w_mode;
    logic [ADDRW-1:0]   w_wr_addr;
    logic [ADDRW-1:0]   w_rd_addr [4];
    logic [c_CMD_W-1:0] w_cmd;

    assign w_mode    = r_buf[(NUM_RD + 1) * ADDRW +: 2];
    assign w_wr_addr = r_buf[ADDRW-1:0];

    // rd_addr[0] sits just below mode; unused slots tie to zero
    for (genvar i = 0; i < 4; i++) begin : g_rd_addr
        if (i < NUM_RD) begin : g_used
            assign w_rd_addr[i] = r_buf[(NUM_RD - i) * ADDRW +: ADDRW];
        end else begin : g_unused
            assign w_rd_addr[i] = '0;
        end
    end

    assign w_ack_exp = {1'b1, (r_step == c_STEP_OP) ? ACCEL_ID : MEM_ID};

    accel_watchdog #(
        .WIDTH (TO_W),
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_wd_clear),
        .enable  (w_wd_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_err   <= 1'b0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_buf <= req_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_err_nxt   = r_err;
        w_load      = 1'b0;
        w_wd_clear  = 1'b0;
        w_wd_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_load      = 1'b1;
                    w_step_nxt  = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (arb_grant) begin
                    w_wd_clear  = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_wd_en = 1'b1;
                // A matching ACK on the expiry cycle takes priority over the error
                if (ack_in == w_ack_exp) begin
                    if (r_step == c_STEP_WR) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_step_nxt  = r_step + 3'd1;
                        w_state_nxt = ST_ISSUE;
                    end
                end else if (w_expired) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (compq_ready_in) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cmd = '0;
        if (r_step < c_STEP_OP) begin
            w_cmd[c_OFS_ADDR +: ADDRW] = w_rd_addr[r_step[1:0]];
            w_cmd[c_OFS_AUX  +: 2]     = r_step[1:0];
            w_cmd[c_OFS_DST  +: 2]     = ACCEL_ID;
            w_cmd[c_OFS_SRC  +: 2]     = MEM_ID;
            w_cmd[c_OFS_OP   +: 2]     = c_OP_RD;
        end else if (r_step == c_STEP_OP) begin
            w_cmd[c_OFS_AUX  +: 2]     = {w_mode[1], w_mode[0]};
            w_cmd[c_OFS_DST  +: 2]     = ACCEL_ID;
            w_cmd[c_OFS_SRC  +: 2]     = ACCEL_ID;
            w_cmd[c_OFS_OP   +: 2]     = c_OP_OP;
        end else begin
            w_cmd[c_OFS_ADDR +: ADDRW] = w_wr_addr;
            w_cmd[c_OFS_DST  +: 2]     = MEM_ID;
            w_cmd[c_OFS_SRC  +: 2]     = ACCEL_ID;
            w_cmd[c_OFS_OP   +: 2]     = c_OP_WR;
        end
    end

    always_comb begin
        ready_req_out   = (r_state == ST_IDLE);
        arb_req         = (r_state == ST_ISSUE);
        compq_valid_out = (r_state == ST_DONE);
        data_out        = '0;
        compq_data_out  = '0;
        if ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) begin
            data_out = w_cmd;
        end
        if (r_state == ST_DONE) begin
            compq_data_out = {r_err, w_wr_addr};
        end
    end

`ifdef ACCEL_SEQ_PERF_EN
    logic w_done_hs;

    assign w_done_hs = (r_state == ST_DONE) && compq_ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_done <= '0;
            perf_err  <= '0;
        end else if (w_done_hs) begin
            if (perf_done != 16'hFFFF) begin
                perf_done <= perf_done + 16'd1;
            end
            if (r_err && (perf_err != 16'hFFFF)) begin
                perf_err <= perf_err + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_accel_seq_fsm.sv
//==============================================================================
// Module      : tb_accel_seq_fsm
// Description : Directed bench for accel_seq_fsm (NUM_RD=2, TIMEOUT=8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_accel_seq_fsm;

    localparam int ADDRW  = 24;
    localparam int NUM_RD = 2;
    localparam int RQW    = (NUM_RD + 1) * ADDRW + 2;

    localparam logic [RQW-1:0] REQ_A = {2'b10, 24'h111111, 24'h222222, 24'h333333};
    localparam logic [RQW-1:0] REQ_B = {2'b01, 24'hABCDEF, 24'h123456, 24'h0F0F0F};

    localparam logic [31:0] RD0  = 32'h11111121;
    localparam logic [31:0] RD1  = 32'h22222261;
    localparam logic [31:0] OPA  = 32'h000000AB;
    localparam logic [31:0] WRA  = 32'h3333330A;
    localparam logic [31:0] RDB0 = 32'hABCDEF21;
    localparam logic [31:0] RDB1 = 32'h12345661;
    localparam logic [31:0] OPB  = 32'h0000006B;
    localparam logic [24:0] CD_OK  = 25'h0333333;
    localparam logic [24:0] CD_ERR = 25'h1333333;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic [RQW-1:0]  req_data = '0;
    logic            ready_req_out;
    logic            arb_req;
    logic            arb_grant = 1'b0;
    logic [2:0]      ack_in = '0;
    logic [31:0]     data_out;
    logic            compq_ready_in = 1'b0;
    logic            compq_valid_out;
    logic [24:0]     compq_data_out;
`ifdef ACCEL_SEQ_PERF_EN
    logic [15:0]     perf_done;
    logic [15:0]     perf_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    accel_seq_fsm #(
        .ADDRW    (ADDRW),
        .ACCEL_ID (2'b10),
        .MEM_ID   (2'b00),
        .NUM_RD   (NUM_RD),
        .TO_W     (12),
        .TIMEOUT  (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .ready_req_out   (ready_req_out),
        .arb_req         (arb_req),
        .arb_grant       (arb_grant),
        .ack_in          (ack_in),
        .data_out        (data_out),
        .compq_ready_in  (compq_ready_in),
        .compq_valid_out (compq_valid_out),
        .compq_data_out  (compq_data_out)
`ifdef ACCEL_SEQ_PERF_EN
        ,
        .perf_done       (perf_done),
        .perf_err        (perf_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rv;
        logic        g;
        logic [2:0]  ack;
        logic        cr;
        logic        rdy;
        logic        arq;
        logic [31:0] dout;
        logic        cv;
        logic [24:0] cd;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic g, input logic [2:0] ack, input logic cr);
        req_valid      = rv;
        arb_grant      = g;
        ack_in         = ack;
        compq_ready_in = cr;
    endtask

    task automatic expect_out(input string tag, input logic rdy, input logic arq,
                              input logic [31:0] dout, input logic cv, input logic [24:0] cd);
        chk({tag, ".ready"}, 32'(ready_req_out), 32'(rdy));
        chk({tag, ".arb_req"}, 32'(arb_req), 32'(arq));
        chk({tag, ".data_out"}, data_out, dout);
        chk({tag, ".compq_valid"}, 32'(compq_valid_out), 32'(cv));
        chk({tag, ".compq_data"}, 32'(compq_data_out), 32'(cd));
    endtask

    task automatic send_req(input string tag, input logic [RQW-1:0] d);
        req_data = d;
        drive(1'b1, 1'b0, 3'b000, 1'b0);
        expect_out({tag, ".accept"}, 1'b1, 1'b0, 32'h0, 1'b0, 25'h0);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_phase(input string tag, input int gdelay, input int adelay,
                            input logic [2:0] ackv, input logic [31:0] word);
        for (int k = 0; k < gdelay; k++) begin
            drive(1'b0, 1'b0, 3'b000, 1'b0);
            expect_out({tag, ".hold"}, 1'b0, 1'b1, word, 1'b0, 25'h0);
            @(negedge clk);
        end
        drive(1'b0, 1'b1, 3'b000, 1'b0);
        expect_out({tag, ".grant"}, 1'b0, 1'b1, word, 1'b0, 25'h0);
        @(negedge clk);
        for (int k = 0; k < adelay; k++) begin
            drive(1'b0, 1'b0, 3'b000, 1'b0);
            expect_out({tag, ".wait"}, 1'b0, 1'b0, word, 1'b0, 25'h0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, ackv, 1'b0);
        expect_out({tag, ".ack"}, 1'b0, 1'b0, word, 1'b0, 25'h0);
        @(negedge clk);
    endtask

    task automatic finish_done(input string tag, input logic [24:0] cd);
        drive(1'b0, 1'b0, 3'b000, 1'b1);
        expect_out({tag, ".done"}, 1'b0, 1'b0, 32'h0, 1'b1, cd);
        @(negedge clk);
    endtask

    initial begin
        // Nominal request, one record per clock cycle
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 25'h0};
        tbl[1]  = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, RD0,   1'b0, 25'h0};
        tbl[2]  = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, RD0,   1'b0, 25'h0};
        tbl[3]  = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, RD0,   1'b0, 25'h0};
        tbl[4]  = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, RD0,   1'b0, 25'h0};
        tbl[5]  = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, RD1,   1'b0, 25'h0};
        tbl[6]  = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, RD1,   1'b0, 25'h0};
        tbl[7]  = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, RD1,   1'b0, 25'h0};
        tbl[8]  = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, RD1,   1'b0, 25'h0};
        tbl[9]  = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, OPA,   1'b0, 25'h0};
        tbl[10] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, OPA,   1'b0, 25'h0};
        tbl[11] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, OPA,   1'b0, 25'h0};
        tbl[12] = '{1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, OPA,   1'b0, 25'h0};
        tbl[13] = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, WRA,   1'b0, 25'h0};
        tbl[14] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, WRA,   1'b0, 25'h0};
        tbl[15] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, WRA,   1'b0, 25'h0};
        tbl[16] = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, WRA,   1'b0, 25'h0};
        tbl[17] = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, CD_OK};
        tbl[18] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 25'h0};

        @(posedge clk);
        @(negedge clk);
        expect_out("reset", 1'b1, 1'b0, 32'h0, 1'b0, 25'h0);
        rst_n = 1'b1;

        // Test 1: nominal
        req_data = REQ_A;
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rv, tbl[i].g, tbl[i].ack, tbl[i].cr);
            expect_out($sformatf("nom[%0d]", i), tbl[i].rdy, tbl[i].arq, tbl[i].dout,
                       tbl[i].cv, tbl[i].cd);
            @(negedge clk);
        end

        // Test 2: grant withheld in step 1
        send_req("t2", REQ_A);
        do_phase("t2.rd0", 0, 1, 3'b100, RD0);
        do_phase("t2.rd1", 10, 1, 3'b100, RD1);
        do_phase("t2.op", 0, 1, 3'b110, OPA);
        do_phase("t2.wr", 0, 1, 3'b100, WRA);
        finish_done("t2", CD_OK);

        // Test 3: accelerator ACK during a read wait is ignored
        send_req("t3", REQ_A);
        drive(1'b0, 1'b1, 3'b000, 1'b0);
        expect_out("t3.grant", 1'b0, 1'b1, RD0, 1'b0, 25'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b110, 1'b0);
        expect_out("t3.wrong_ack", 1'b0, 1'b0, RD0, 1'b0, 25'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b010, 1'b0);
        expect_out("t3.still_wait", 1'b0, 1'b0, RD0, 1'b0, 25'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b100, 1'b0);
        expect_out("t3.good_ack", 1'b0, 1'b0, RD0, 1'b0, 25'h0);
        @(negedge clk);
        do_phase("t3.rd1", 0, 0, 3'b100, RD1);
        do_phase("t3.op", 0, 0, 3'b110, OPA);
        do_phase("t3.wr", 0, 0, 3'b100, WRA);
        finish_done("t3", CD_OK);

        // Test 4a: OP ACK never arrives, watchdog fires after 8 WAIT cycles
        send_req("t4a", REQ_A);
        do_phase("t4a.rd0", 0, 0, 3'b100, RD0);
        do_phase("t4a.rd1", 0, 0, 3'b100, RD1);
        drive(1'b0, 1'b1, 3'b000, 1'b0);
        expect_out("t4a.op_grant", 1'b0, 1'b1, OPA, 1'b0, 25'h0);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b0, 3'b000, 1'b0);
            expect_out($sformatf("t4a.wait%0d", k), 1'b0, 1'b0, OPA, 1'b0, 25'h0);
            @(negedge clk);
        end
        finish_done("t4a", CD_ERR);

        // Test 4b: ACK on the 8th WAIT cycle beats the watchdog
        send_req("t4b", REQ_A);
        do_phase("t4b.rd0", 0, 0, 3'b100, RD0);
        do_phase("t4b.rd1", 0, 0, 3'b100, RD1);
        do_phase("t4b.op", 0, 7, 3'b110, OPA);
        do_phase("t4b.wr", 0, 0, 3'b100, WRA);
        finish_done("t4b", CD_OK);

`ifdef ACCEL_SEQ_PERF_EN
        chk("perf_done", 32'(perf_done), 32'd5);
        chk("perf_err", 32'(perf_err), 32'd1);
`endif

        // Test 5: completion back-pressure, then back-to-back request
        send_req("t5", REQ_A);
        do_phase("t5.rd0", 0, 0, 3'b100, RD0);
        do_phase("t5.rd1", 0, 0, 3'b100, RD1);
        do_phase("t5.op", 0, 0, 3'b110, OPA);
        do_phase("t5.wr", 0, 0, 3'b100, WRA);
        req_data = REQ_B;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 3'b000, 1'b0);
            expect_out($sformatf("t5.stall%0d", k), 1'b0, 1'b0, 32'h0, 1'b1, CD_OK);
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 3'b000, 1'b1);
        expect_out("t5.handshake", 1'b0, 1'b0, 32'h0, 1'b1, CD_OK);
        @(negedge clk);
        send_req("t5.b2b", REQ_B);
        do_phase("t5.rdb0", 0, 0, 3'b100, RDB0);
        do_phase("t5.rdb1", 0, 0, 3'b100, RDB1);

        // Test 6: asynchronous reset while waiting on the OP ACK
        drive(1'b0, 1'b1, 3'b000, 1'b0);
        expect_out("t6.op_grant", 1'b0, 1'b1, OPB, 1'b0, 25'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 1'b0);
        expect_out("t6.op_wait", 1'b0, 1'b0, OPB, 1'b0, 25'h0);
        #2 rst_n = 1'b0;
        #1 expect_out("t6.async_rst", 1'b1, 1'b0, 32'h0, 1'b0, 25'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 3'b110, 1'b1);
            expect_out($sformatf("t6.post%0d", k), 1'b1, 1'b0, 32'h0, 1'b0, 25'h0);
            @(negedge clk);
        end
`ifdef ACCEL_SEQ_PERF_EN
        chk("perf_done_rst", 32'(perf_done), 32'd0);
        chk("perf_err_rst", 32'(perf_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
